// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared encodings and constants for the cache-to-memory arbiter
package mem_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_e;

    localparam int LINE_WORDS_DEF = 4;

    localparam logic ICACHE = 1'b0;
    localparam logic DCACHE = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - combinational two-request round-robin picker
module rr_arb2 (
    input  logic [1:0] req_i,
    input  logic       last_i,
    output logic [1:0] gnt_o
);

    // On a tie the client that did not win last time takes the grant.
    assign gnt_o[0] = req_i[0] & (~req_i[1] | last_i);
    assign gnt_o[1] = req_i[1] & (~req_i[0] | ~last_i);

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - icache/dcache arbiter that locks memory to one cache per line fill
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int LINE_WORDS = LINE_WORDS_DEF,
    parameter int CNT_W      = 3
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [31:0] i_c0_addr,
    input  logic        i_c0_ren,
    input  logic        i_c0_wen,
    input  logic [31:0] i_c0_wdata,
    output logic        o_c0_ready,
    output logic [31:0] o_c0_rdata,
    output logic        o_c0_valid,
    input  logic [31:0] i_c1_addr,
    input  logic        i_c1_ren,
    input  logic        i_c1_wen,
    input  logic [31:0] i_c1_wdata,
    output logic        o_c1_ready,
    output logic [31:0] o_c1_rdata,
    output logic        o_c1_valid,
    input  logic        i_mem_ready,
    output logic [31:0] o_mem_addr,
    output logic        o_mem_ren,
    output logic        o_mem_wen,
    output logic [31:0] o_mem_wdata,
    input  logic [31:0] i_mem_rdata,
    input  logic        i_mem_valid
);

    localparam logic [CNT_W-1:0] LINE_CNT = CNT_W'(LINE_WORDS);
    localparam logic [CNT_W-1:0] LAST_RET = CNT_W'(LINE_WORDS - 1);

    arb_state_e       state_q, state_d;
    logic             owner_q, owner_d;
    logic             rr_last_q, rr_last_d;
    logic [CNT_W-1:0] issued_q, issued_d;
    logic [CNT_W-1:0] returned_q, returned_d;

    logic [1:0]  gnt;
    logic        sel;
    logic        fwd;
    logic        fwd_ren;
    logic        fwd_wen;
    logic        sel_ready;
    logic        sel_valid;
    logic        sel_ren;
    logic        sel_wen;
    logic        room;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;

    rr_arb2 u_rr_arb2 (
        .req_i  ({i_c1_ren | i_c1_wen, i_c0_ren | i_c0_wen}),
        .last_i (rr_last_q),
        .gnt_o  (gnt)
    );

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        rr_last_d  = rr_last_q;
        issued_d   = issued_q;
        returned_d = returned_q;
        sel        = ICACHE;
        fwd        = 1'b0;
        fwd_ren    = 1'b0;
        fwd_wen    = 1'b0;
        sel_ready  = 1'b0;
        sel_valid  = 1'b0;
        room       = 1'b0;

        if (state_q == BURST) begin
            sel = owner_q;
        end else if (gnt[1]) begin
            sel = DCACHE;
        end
        sel_ren   = (sel == DCACHE) ? i_c1_ren   : i_c0_ren;
        sel_wen   = (sel == DCACHE) ? i_c1_wen   : i_c0_wen;
        sel_addr  = (sel == DCACHE) ? i_c1_addr  : i_c0_addr;
        sel_wdata = (sel == DCACHE) ? i_c1_wdata : i_c0_wdata;

        case (state_q)
            IDLE: begin
                if (|gnt) begin
                    fwd       = 1'b1;
                    fwd_ren   = sel_ren;
                    fwd_wen   = sel_wen;
                    sel_ready = i_mem_ready;
                    if (sel_ren && i_mem_ready) begin
                        state_d    = BURST;
                        owner_d    = sel;
                        rr_last_d  = sel;
                        issued_d   = CNT_W'(1);
                        returned_d = '0;
                    end else if (sel_wen && i_mem_ready) begin
                        rr_last_d = sel;
                    end
                end
            end
            BURST: begin
                // Writes from the owner are held off so read data stays in order with the fill.
                fwd       = 1'b1;
                room      = issued_q < LINE_CNT;
                fwd_ren   = sel_ren && room;
                sel_ready = i_mem_ready && !sel_wen && room;
                if (fwd_ren && i_mem_ready) begin
                    issued_d = issued_q + CNT_W'(1);
                end
                if (i_mem_valid) begin
                    sel_valid = 1'b1;
                    if (returned_q == LAST_RET) begin
                        state_d    = IDLE;
                        issued_d   = '0;
                        returned_d = '0;
                    end else begin
                        returned_d = returned_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= IDLE;
            owner_q    <= ICACHE;
            rr_last_q  <= DCACHE;
            issued_q   <= '0;
            returned_q <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            rr_last_q  <= rr_last_d;
            issued_q   <= issued_d;
            returned_q <= returned_d;
        end
    end

    // Every path is combinational, so reset has to gate the outputs directly.
    assign o_mem_addr  = (i_rst_n && fwd) ? sel_addr  : 32'd0;
    assign o_mem_wdata = (i_rst_n && fwd) ? sel_wdata : 32'd0;
    assign o_mem_ren   = i_rst_n && fwd_ren;
    assign o_mem_wen   = i_rst_n && fwd_wen;

    assign o_c0_ready  = i_rst_n && sel_ready && (sel == ICACHE);
    assign o_c1_ready  = i_rst_n && sel_ready && (sel == DCACHE);
    assign o_c0_valid  = i_rst_n && sel_valid && (sel == ICACHE);
    assign o_c1_valid  = i_rst_n && sel_valid && (sel == DCACHE);
    assign o_c0_rdata  = i_rst_n ? i_mem_rdata : 32'd0;
    assign o_c1_rdata  = i_rst_n ? i_mem_rdata : 32'd0;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] i_c0_addr, i_c0_wdata, i_c1_addr, i_c1_wdata;
    logic        i_c0_ren, i_c0_wen, i_c1_ren, i_c1_wen;
    logic        o_c0_ready, o_c0_valid, o_c1_ready, o_c1_valid;
    logic [31:0] o_c0_rdata, o_c1_rdata;
    logic        i_mem_ready, i_mem_valid;
    logic [31:0] o_mem_addr, o_mem_wdata, i_mem_rdata;
    logic        o_mem_ren, o_mem_wen;

    always #5 clk = ~clk;

    mem_arbiter #(.LINE_WORDS(4), .CNT_W(3)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_c0_addr(i_c0_addr), .i_c0_ren(i_c0_ren), .i_c0_wen(i_c0_wen), .i_c0_wdata(i_c0_wdata),
        .o_c0_ready(o_c0_ready), .o_c0_rdata(o_c0_rdata), .o_c0_valid(o_c0_valid),
        .i_c1_addr(i_c1_addr), .i_c1_ren(i_c1_ren), .i_c1_wen(i_c1_wen), .i_c1_wdata(i_c1_wdata),
        .o_c1_ready(o_c1_ready), .o_c1_rdata(o_c1_rdata), .o_c1_valid(o_c1_valid),
        .i_mem_ready(i_mem_ready), .o_mem_addr(o_mem_addr), .o_mem_ren(o_mem_ren),
        .o_mem_wen(o_mem_wen), .o_mem_wdata(o_mem_wdata),
        .i_mem_rdata(i_mem_rdata), .i_mem_valid(i_mem_valid)
    );

    typedef struct {
        logic        c0_ren, c0_wen, c1_ren, c1_wen, rdy;
        logic [31:0] addr;
        logic        ren, wen;
        logic [31:0] wdata;
        logic [1:0]  ready;
    } vec_t;

    int n_chk = 0;
    int n_fail = 0;

    int          rd_left[2];
    logic [31:0] rd_addr[2];
    logic [1:0]  hold_ren;
    logic [1:0]  wr_pend;
    logic [31:0] wr_addr[2];
    logic [31:0] wr_data[2];
    logic        mem_rdy, extra_valid;
    logic        pend_v, pend_tag;
    logic [31:0] pend_d;
    logic [31:0] acc_addr[$];
    logic        acc_tag[$];
    int          vcnt[2];
    int          last_vcyc[2];
    int          first_acc_cyc[2];
    int          cyc;
    int          mem_wr_n, mem_wr_cyc;
    logic [31:0] mem_wr_addr, mem_wr_data;
    logic        s_mem_ren;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic any_out();
        return |{o_mem_addr, o_mem_wdata, o_mem_ren, o_mem_wen, o_c0_ready, o_c0_rdata,
                 o_c0_valid, o_c1_ready, o_c1_rdata, o_c1_valid};
    endfunction

    // One clock: two caches issuing line reads / single writes, memory answering one cycle later.
    task automatic cycle();
        logic acc0, acc1;
        i_c0_ren    = (rd_left[0] > 0) || hold_ren[0];
        i_c0_wen    = !i_c0_ren && wr_pend[0];
        i_c0_addr   = i_c0_ren ? rd_addr[0] : wr_addr[0];
        i_c0_wdata  = wr_data[0];
        i_c1_ren    = (rd_left[1] > 0) || hold_ren[1];
        i_c1_wen    = !i_c1_ren && wr_pend[1];
        i_c1_addr   = i_c1_ren ? rd_addr[1] : wr_addr[1];
        i_c1_wdata  = wr_data[1];
        i_mem_ready = mem_rdy;
        i_mem_valid = pend_v || extra_valid;
        i_mem_rdata = pend_d;
        #1;
        cyc++;
        if (pend_v) begin
            chk("valid_steer", {30'd0, o_c1_valid, o_c0_valid}, pend_tag ? 32'd2 : 32'd1);
            chk("rdata_copy", pend_tag ? o_c1_rdata : o_c0_rdata, pend_d);
        end else begin
            chk("no_owner_valid", {30'd0, o_c1_valid, o_c0_valid}, 32'd0);
        end
        if (o_c0_valid) begin vcnt[0]++; last_vcyc[0] = cyc; end
        if (o_c1_valid) begin vcnt[1]++; last_vcyc[1] = cyc; end
        acc0 = i_c0_ren && o_c0_ready;
        acc1 = i_c1_ren && o_c1_ready;
        if (acc0) begin
            if (rd_left[0] > 0) rd_left[0]--;
            rd_addr[0] += 32'd4;
            if (first_acc_cyc[0] < 0) first_acc_cyc[0] = cyc;
        end
        if (acc1) begin
            if (rd_left[1] > 0) rd_left[1]--;
            rd_addr[1] += 32'd4;
            if (first_acc_cyc[1] < 0) first_acc_cyc[1] = cyc;
        end
        if (i_c0_wen && o_c0_ready) wr_pend[0] = 1'b0;
        if (i_c1_wen && o_c1_ready) wr_pend[1] = 1'b0;
        s_mem_ren = o_mem_ren;
        if (o_mem_ren && i_mem_ready) begin
            acc_addr.push_back(o_mem_addr);
            acc_tag.push_back(acc1);
            pend_v   = 1'b1;
            pend_d   = o_mem_addr ^ 32'h5A5A_0000;
            pend_tag = acc1;
        end else begin
            pend_v = 1'b0;
        end
        if (o_mem_wen && i_mem_ready) begin
            mem_wr_n++;
            mem_wr_addr = o_mem_addr;
            mem_wr_data = o_mem_wdata;
            mem_wr_cyc  = cyc;
        end
        @(negedge clk);
    endtask

    task automatic run_until(input int c, input int target, input int budget, input string name);
        int n = 0;
        while (vcnt[c] < target && n < budget) begin
            cycle();
            n++;
        end
        chk(name, {31'd0, vcnt[c] >= target}, 32'd1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        rd_left = '{0, 0};
        rd_addr = '{32'd0, 32'd0};
        wr_addr = '{32'd0, 32'd0};
        wr_data = '{32'd0, 32'd0};
        hold_ren = 2'b00;
        wr_pend = 2'b00;
        mem_rdy = 1'b1;
        extra_valid = 1'b0;
        pend_v = 1'b0;
        pend_tag = 1'b0;
        pend_d = 32'd0;
        acc_addr.delete();
        acc_tag.delete();
        vcnt = '{0, 0};
        last_vcyc = '{-1, -1};
        first_acc_cyc = '{-1, -1};
        mem_wr_n = 0;
        mem_wr_cyc = -1;
        cyc = 0;
        i_c0_ren = 1'b1; i_c0_wen = 1'b0; i_c0_addr = 32'h1234; i_c0_wdata = 32'h1;
        i_c1_ren = 1'b0; i_c1_wen = 1'b1; i_c1_addr = 32'hFFFF_FFFF; i_c1_wdata = 32'h2;
        i_mem_ready = 1'b1; i_mem_valid = 1'b1; i_mem_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        #1;
        chk("reset_outputs_zero", {31'd0, any_out()}, 32'd0);
        i_c0_ren = 1'b0; i_c1_wen = 1'b0; i_mem_valid = 1'b0; i_mem_rdata = 32'd0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    vec_t vecs[9];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // rr_last starts at 1; accepted writes (ready=1) move it, unaccepted requests do not.
        vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0,    1'b0, 1'b0, 32'h0,        2'b00};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h1000, 1'b0, 1'b1, 32'h1111_1111, 2'b00};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h1000, 1'b0, 1'b1, 32'h1111_1111, 2'b01};
        vecs[3] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h2000, 1'b0, 1'b1, 32'h2222_2222, 2'b10};
        vecs[4] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h2000, 1'b0, 1'b1, 32'h2222_2222, 2'b10};
        vecs[5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h1000, 1'b0, 1'b1, 32'h1111_1111, 2'b01};
        vecs[6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h2000, 1'b1, 1'b0, 32'h2222_2222, 2'b00};
        vecs[7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h1000, 1'b1, 1'b0, 32'h1111_1111, 2'b00};
        vecs[8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h2000, 1'b1, 1'b0, 32'h2222_2222, 2'b00};

        do_reset();
        for (int i = 0; i < 9; i++) begin
            i_c0_ren = vecs[i].c0_ren; i_c0_wen = vecs[i].c0_wen;
            i_c1_ren = vecs[i].c1_ren; i_c1_wen = vecs[i].c1_wen;
            i_c0_addr = 32'h1000; i_c0_wdata = 32'h1111_1111;
            i_c1_addr = 32'h2000; i_c1_wdata = 32'h2222_2222;
            i_mem_ready = vecs[i].rdy; i_mem_valid = 1'b0;
            #1;
            chk($sformatf("vec%0d_addr", i),  o_mem_addr, vecs[i].addr);
            chk($sformatf("vec%0d_ren", i),   {31'd0, o_mem_ren}, {31'd0, vecs[i].ren});
            chk($sformatf("vec%0d_wen", i),   {31'd0, o_mem_wen}, {31'd0, vecs[i].wen});
            chk($sformatf("vec%0d_wdata", i), o_mem_wdata, vecs[i].wdata);
            chk($sformatf("vec%0d_ready", i), {30'd0, o_c1_ready, o_c0_ready}, {30'd0, vecs[i].ready});
            @(negedge clk);
        end

        // Single c0 line fill
        do_reset();
        rd_left[0] = 4; rd_addr[0] = 32'h100;
        run_until(0, 4, 30, "A_fill_complete");
        chk("A_accepts", acc_addr.size(), 32'd4);
        for (int i = 0; i < 4; i++)
            if (i < acc_addr.size()) chk($sformatf("A_addr%0d", i), acc_addr[i], 32'h100 + 32'(4 * i));
        chk("A_c1_valid_count", vcnt[1], 32'd0);
        wr_pend[1] = 1'b1; wr_addr[1] = 32'h44; wr_data[1] = 32'h77;
        cycle();
        chk("A_idle_write_forwarded", mem_wr_n, 32'd1);

        // Simultaneous fills: c0 first, c1 right after retirement
        do_reset();
        rd_left = '{4, 4}; rd_addr = '{32'h200, 32'h400};
        run_until(1, 4, 40, "B_c1_fill_complete");
        chk("B_c0_valid_count", vcnt[0], 32'd4);
        chk("B_accepts", acc_addr.size(), 32'd8);
        for (int i = 0; i < 8; i++)
            if (i < acc_addr.size()) begin
                chk($sformatf("B_addr%0d", i), acc_addr[i],
                    (i < 4) ? 32'h200 + 32'(4 * i) : 32'h400 + 32'(4 * (i - 4)));
                chk($sformatf("B_tag%0d", i), {31'd0, acc_tag[i]}, (i < 4) ? 32'd0 : 32'd1);
            end
        chk("B_c1_wins_next_cycle", first_acc_cyc[1], last_vcyc[0] + 1);

        // c1 write hit while idle, then a tie goes to c0
        do_reset();
        wr_pend[1] = 1'b1; wr_addr[1] = 32'h80; wr_data[1] = 32'hDEAD_BEEF;
        cycle();
        chk("C_write_count", mem_wr_n, 32'd1);
        chk("C_write_addr", mem_wr_addr, 32'h80);
        chk("C_write_data", mem_wr_data, 32'hDEAD_BEEF);
        chk("C_write_same_cycle", mem_wr_cyc, 32'd1);
        rd_left = '{4, 4}; rd_addr = '{32'hA00, 32'hB00};
        cycle();
        chk("C_tie_accepts", acc_tag.size(), 32'd1);
        if (acc_tag.size() > 0) chk("C_tie_to_c0", {31'd0, acc_tag[0]}, 32'd0);
        run_until(1, 4, 40, "C_drain");

        // c1 write arriving mid-burst waits for the exit
        do_reset();
        rd_left[0] = 4; rd_addr[0] = 32'h300;
        cycle();
        wr_pend[1] = 1'b1; wr_addr[1] = 32'h90; wr_data[1] = 32'h1234_5678;
        run_until(0, 4, 30, "D_fill_complete");
        chk("D_no_write_in_burst", mem_wr_n, 32'd0);
        cycle();
        chk("D_write_after_exit", mem_wr_n, 32'd1);
        chk("D_write_cycle", mem_wr_cyc, last_vcyc[0] + 1);
        chk("D_write_addr", mem_wr_addr, 32'h90);
        chk("D_write_data", mem_wr_data, 32'h1234_5678);

        // Memory stall mid-burst with the owner holding ren high past the line
        do_reset();
        rd_left[0] = 4; rd_addr[0] = 32'h500; hold_ren[0] = 1'b1;
        cycle();
        cycle();
        mem_rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk($sformatf("E_ren_held%0d", i), {31'd0, s_mem_ren}, 32'd1);
            chk($sformatf("E_issued_hold%0d", i), acc_addr.size(), 32'd2);
        end
        mem_rdy = 1'b1;
        run_until(0, 4, 30, "E_fill_complete");
        chk("E_ren_masked_at_exit", {31'd0, s_mem_ren}, 32'd0);
        hold_ren[0] = 1'b0;
        chk("E_accepts", acc_addr.size(), 32'd4);
        chk("E_valids", vcnt[0], 32'd4);

        // Asynchronous reset mid-burst, then a late valid
        do_reset();
        rd_left[0] = 4; rd_addr[0] = 32'h600;
        run_until(0, 2, 20, "F_two_valids");
        i_c0_ren = 1'b1; i_mem_ready = 1'b1; i_mem_valid = 1'b1;
        #1;
        chk("F_pre_reset_ren", {31'd0, o_mem_ren}, 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("F_async_outputs_zero", {31'd0, any_out()}, 32'd0);
        rd_left[0] = 0; pend_v = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        extra_valid = 1'b1;
        wr_pend[1] = 1'b1; wr_addr[1] = 32'h88; wr_data[1] = 32'h55;
        cycle();
        extra_valid = 1'b0;
        chk("F_late_valid_c0", vcnt[0], 32'd2);
        chk("F_late_valid_c1", vcnt[1], 32'd0);
        chk("F_idle_after_reset", mem_wr_n, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
